// File: rtl/display_framebuffer.sv
`default_nettype none
// ============================================================================
//  Module      : display_framebuffer
//  Description : Double-buffered pixel framebuffer. The composer writes the
//                back buffer and the scan driver reads the front buffer. Flips
//                wait for the end of a scanned frame so a visible frame is
//                never torn. The optional clear engine (built only when
//                DISPLAY_FRAMEBUFFER_CLEAR_EN is defined) zeroes the back
//                buffer one word per cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module display_framebuffer #(
    parameter int SEGMENTS = 1,
    parameter int ROWS     = 8,
    parameter int COLUMNS  = 32,
    parameter int WIDTH    = 24
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [SEGMENTS-1:0]         wen,
    input  logic [$clog2(ROWS)-1:0]     wrow,
    input  logic [$clog2(COLUMNS)-1:0]  wcol,
    input  logic [WIDTH*SEGMENTS-1:0]   wdata,
    output logic                        wready,
    input  logic                        ren,
    input  logic [$clog2(ROWS)-1:0]     rrow,
    input  logic [$clog2(COLUMNS)-1:0]  rcol,
    output logic [WIDTH*SEGMENTS-1:0]   rdata,
    input  logic                        flip_req,
    output logic                        flip_pending,
    output logic                        front,
    input  logic                        clear,
    output logic                        busy
);

    localparam int c_RB    = $clog2(ROWS);
    localparam int c_CB    = $clog2(COLUMNS);
    localparam int c_WORDS = ROWS * COLUMNS;
    localparam int c_DEPTH = 2 * c_WORDS;
    localparam int c_AW    = $clog2(c_DEPTH);

    // Storage is packed densely as buffer*ROWS*COLUMNS + row*COLUMNS + col so
    // non-power-of-two geometries waste no words.
    function automatic logic [c_AW-1:0] f_addr(input logic b,
                                               input logic [c_RB-1:0] r,
                                               input logic [c_CB-1:0] c);
        return c_AW'(int'(b) * c_WORDS + int'(r) * COLUMNS + int'(c));
    endfunction

    logic [SEGMENTS-1:0][WIDTH-1:0] r_mem [0:c_DEPTH-1] = '{default: '0};
    logic [SEGMENTS-1:0][WIDTH-1:0] r_rdata;
    logic                           r_front;
    logic                           r_pending;

    logic            w_busy;
    logic            w_start;
    logic [c_AW-1:0] w_caddr;
    logic            w_win;
    logic            w_rin;
    logic            w_frame_end;
    logic            w_flip_ok;
    logic [c_AW-1:0] w_waddr;
    logic [c_AW-1:0] w_raddr;

    assign w_win       = (int'(wrow) < ROWS) && (int'(wcol) < COLUMNS);
    assign w_rin       = (int'(rrow) < ROWS) && (int'(rcol) < COLUMNS);
    assign w_waddr     = f_addr(!r_front, wrow, wcol);
    assign w_raddr     = f_addr(r_front, rrow, rcol);
    assign w_frame_end = ren && (int'(rrow) == ROWS - 1) && (int'(rcol) == COLUMNS - 1);

`ifdef DISPLAY_FRAMEBUFFER_CLEAR_EN
    localparam logic [0:0] c_IDLE  = 1'b0;
    localparam logic [0:0] c_CLEAR = 1'b1;

    logic [0:0]      r_state;
    logic [c_RB-1:0] r_crow;
    logic [c_CB-1:0] r_ccol;
    logic            w_last;

    assign w_busy  = (r_state == c_CLEAR);
    assign w_start = (r_state == c_IDLE) && clear;
    assign w_last  = (int'(r_crow) == ROWS - 1) && (int'(r_ccol) == COLUMNS - 1);
    assign w_caddr = f_addr(!r_front, r_crow, r_ccol);

    // Clear sweep: row-major walk over the back buffer, one word per cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
            r_crow  <= '0;
            r_ccol  <= '0;
        end else if (r_state == c_IDLE) begin
            if (clear) begin
                r_state <= c_CLEAR;
                r_crow  <= '0;
                r_ccol  <= '0;
            end
        end else begin
            if (w_last) begin
                r_state <= c_IDLE;
                r_crow  <= '0;
                r_ccol  <= '0;
            end else if (int'(r_ccol) == COLUMNS - 1) begin
                r_ccol <= '0;
                r_crow <= r_crow + 1'b1;
            end else begin
                r_ccol <= r_ccol + 1'b1;
            end
        end
    end
`else
    logic w_unused_clear;

    assign w_unused_clear = clear;
    assign w_busy         = 1'b0;
    assign w_start        = 1'b0;
    assign w_caddr        = '0;
`endif

    // Storage port: the clear sweep owns the back buffer while busy, otherwise
    // host writes update only the enabled segment slices.
    always_ff @(posedge clk) begin
        if (w_busy) begin
            r_mem[w_caddr] <= '0;
        end else if (w_win) begin
            for (int s = 0; s < SEGMENTS; s++) begin
                if (wen[s]) begin
                    r_mem[w_waddr][s] <= wdata[s*WIDTH +: WIDTH];
                end
            end
        end
    end

    // Registered front-buffer read; out-of-range addresses return zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata <= '0;
        end else if (ren) begin
            r_rdata <= w_rin ? r_mem[w_raddr] : '0;
        end
    end

    // A flip waits for a frame end in idle; a clear starting this cycle also
    // defers it so the flip lands after the sweep completes.
    assign w_flip_ok = w_frame_end && (r_pending || flip_req) && !w_busy && !w_start;

    // Flip bookkeeping: latch a single request, apply it at the frame end.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_front   <= 1'b0;
            r_pending <= 1'b0;
        end else if (w_flip_ok) begin
            r_front   <= ~r_front;
            r_pending <= 1'b0;
        end else if (flip_req) begin
            r_pending <= 1'b1;
        end
    end

    assign rdata        = r_rdata;
    assign front        = r_front;
    assign flip_pending = r_pending;
    assign busy         = w_busy;
    assign wready       = !w_busy;

endmodule
`default_nettype wire

// File: tb/tb_display_framebuffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_display_framebuffer
//  Description : Self-checking bench for display_framebuffer. An 8x32x24
//                instance is compared every cycle against an array-level model;
//                a 3x5 two-segment instance covers segment masks and
//                out-of-range addressing with literal expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_display_framebuffer;

    localparam int R     = 8;
    localparam int C     = 32;
    localparam int TOTAL = R * C;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Main instance
    logic [0:0]  wen = '0;
    logic [2:0]  wrow = '0;
    logic [4:0]  wcol = '0;
    logic [23:0] wdata = '0;
    logic        wready;
    logic        ren = 1'b0;
    logic [2:0]  rrow = '0;
    logic [4:0]  rcol = '0;
    logic [23:0] rdata;
    logic        flip_req = 1'b0;
    logic        flip_pending;
    logic        front;
    logic        clear = 1'b0;
    logic        busy;

    // Two-segment, non-power-of-two instance
    logic [1:0]  wen2 = '0;
    logic [1:0]  wrow2 = '0;
    logic [2:0]  wcol2 = '0;
    logic [47:0] wdata2 = '0;
    logic        wready2;
    logic        ren2 = 1'b0;
    logic [1:0]  rrow2 = '0;
    logic [2:0]  rcol2 = '0;
    logic [47:0] rdata2;
    logic        flip_req2 = 1'b0;
    logic        flip_pending2;
    logic        front2;
    logic        busy2;

    display_framebuffer #(.SEGMENTS(1), .ROWS(R), .COLUMNS(C), .WIDTH(24)) dut (
        .clk(clk), .rst_n(rst_n), .wen(wen), .wrow(wrow), .wcol(wcol),
        .wdata(wdata), .wready(wready), .ren(ren), .rrow(rrow), .rcol(rcol),
        .rdata(rdata), .flip_req(flip_req), .flip_pending(flip_pending),
        .front(front), .clear(clear), .busy(busy)
    );

    display_framebuffer #(.SEGMENTS(2), .ROWS(3), .COLUMNS(5), .WIDTH(24)) dut2 (
        .clk(clk), .rst_n(rst_n), .wen(wen2), .wrow(wrow2), .wcol(wcol2),
        .wdata(wdata2), .wready(wready2), .ren(ren2), .rrow(rrow2), .rcol(rcol2),
        .rdata(rdata2), .flip_req(flip_req2), .flip_pending(flip_pending2),
        .front(front2), .clear(1'b0), .busy(busy2)
    );

    int checks = 0;
    int errors = 0;
    bit started = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model of the main instance ----------------
    logic [23:0] m_mem [0:1][0:R-1][0:C-1] = '{default: '0};
    logic        m_front = 1'b0;
    logic        m_pend  = 1'b0;
    logic [23:0] m_rdata = '0;
    int          m_left  = 0;
    bit          m_bz, m_fe, m_st;
    int          m_k;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_front = 1'b0;
            m_pend  = 1'b0;
            m_rdata = '0;
            m_left  = 0;
        end else begin
            m_bz = (m_left > 0);
            m_fe = ren && (rrow == R - 1) && (rcol == C - 1);
            m_st = 1'b0;
`ifdef DISPLAY_FRAMEBUFFER_CLEAR_EN
            m_st = !m_bz && clear;
`endif
            if (ren) m_rdata = m_mem[m_front][rrow][rcol];
            if (m_bz) begin
                m_k = TOTAL - m_left;
                m_mem[!m_front][m_k / C][m_k % C] = '0;
                m_left--;
            end else if (wen[0]) begin
                m_mem[!m_front][wrow][wcol] = wdata;
            end
            if (m_fe && (m_pend || flip_req) && !m_bz && !m_st) begin
                m_front = !m_front;
                m_pend  = 1'b0;
            end else if (flip_req) begin
                m_pend = 1'b1;
            end
            if (m_st) m_left = TOTAL;
        end
    end

    // Cycle-by-cycle comparison against the model
    always @(negedge clk) begin
        if (started) begin
            chk("rdata", rdata, m_rdata);
            chk("front", front, m_front);
            chk("flip_pending", flip_pending, m_pend);
            chk("busy", busy, m_left > 0);
            chk("wready", wready, !(m_left > 0));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int r, input int c, input logic [23:0] d);
        wen = 1'b1; wrow = 3'(r); wcol = 5'(c); wdata = d;
        tick();
        wen = 1'b0;
    endtask

    task automatic rd(input int r, input int c);
        ren = 1'b1; rrow = 3'(r); rcol = 5'(c);
        tick();
        ren = 1'b0;
    endtask

    task automatic frame_end();
        rd(R - 1, C - 1);
    endtask

    task automatic scan();
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++)
                rd(r, c);
    endtask

    task automatic fill(input logic [23:0] d);
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++)
                wr(r, c, d);
    endtask

    task automatic pulse_flip();
        flip_req = 1'b1;
        tick();
        flip_req = 1'b0;
    endtask

    task automatic wr2(input int r, input int c, input logic [1:0] m, input logic [47:0] d);
        wen2 = m; wrow2 = 2'(r); wcol2 = 3'(c); wdata2 = d;
        tick();
        wen2 = '0;
    endtask

    task automatic rd2(input int r, input int c);
        ren2 = 1'b1; rrow2 = 2'(r); rcol2 = 3'(c);
        tick();
        ren2 = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("reset busy", busy, 1'b0);
        chk("reset pending", flip_pending, 1'b0);
        chk("reset front", front, 1'b0);
        chk("reset rdata", rdata, 24'h0);
        chk("reset wready", wready, 1'b1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    int cnt;

    initial begin
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        started = 1'b1;

        // Reset state and first read
        chk("init front", front, 1'b0);
        chk("init wready", wready, 1'b1);
        chk("init pending", flip_pending, 1'b0);
        chk("init busy", busy, 1'b0);
        rd(0, 0);
        chk("read 0,0 after reset", rdata, 24'h0);

        // Back-buffer write is invisible until a flip
        wr(3, 7, 24'hA5A5A5);
        rd(3, 7);
        chk("write hidden before flip", rdata, 24'h0);
        pulse_flip();
        chk("pending after req", flip_pending, 1'b1);
        scan();
        chk("front after frame", front, 1'b1);
        chk("pending after frame", flip_pending, 1'b0);
        rd(3, 7);
        chk("write visible after flip", rdata, 24'hA5A5A5);

        // Two requests before a frame end give one toggle
        pulse_flip();
        tick();
        pulse_flip();
        chk("pending double req", flip_pending, 1'b1);
        frame_end();
        chk("front single toggle", front, 1'b0);
        chk("pending cleared", flip_pending, 1'b0);
        frame_end();
        chk("no queued flip", front, 1'b0);

        // Request coinciding with the frame-end read applies immediately
        flip_req = 1'b1; ren = 1'b1; rrow = 3'(R - 1); rcol = 5'(C - 1);
        tick();
        flip_req = 1'b0; ren = 1'b0;
        chk("same-cycle flip", front, 1'b1);

        // Segment masks and out-of-range addressing on the 3x5 instance
        wr2(0, 0, 2'b11, 48'hFFFFFF_000000);
        wr2(0, 0, 2'b10, 48'h123456_ABCDEF);
        rd2(2, 5);
        chk("seg oor read", rdata2, 48'h0);
        rd2(0, 0);
        chk("seg hidden", rdata2, 48'h0);
        flip_req2 = 1'b1;
        tick();
        flip_req2 = 1'b0;
        rd2(2, 4);
        chk("seg front", front2, 1'b1);
        rd2(0, 0);
        chk("seg masked write", rdata2, 48'h123456_000000);
        wr2(3, 1, 2'b11, 48'hDEADBE_EF0123);
        rd2(0, 1);
        chk("seg oor write dropped", rdata2, 48'h0);

`ifdef DISPLAY_FRAMEBUFFER_CLEAR_EN
        // front=1: back buffer 0 is filled with ones, then cleared
        fill(24'hFFFFFF);
        clear = 1'b1; flip_req = 1'b1;
        tick();
        clear = 1'b0; flip_req = 1'b0;
        cnt = 0;
        for (int i = 0; i < 400; i++) begin
            wen = 1'b0; ren = 1'b0;
            if (i == 1) begin wen = 1'b1; wrow = 3'd0; wcol = 5'd0; wdata = 24'h777777; end
            if (i == 50) begin ren = 1'b1; rrow = 3'(R - 1); rcol = 5'(C - 1); end
            @(negedge clk);
            if (busy) cnt++;
            if (!busy) break;
            @(posedge clk);
            #1;
        end
        #1;
        wen = 1'b0; ren = 1'b0;
        chk("busy cycles", cnt, TOTAL);
        chk("no flip during clear", front, 1'b1);
        chk("pending kept", flip_pending, 1'b1);
        frame_end();
        chk("flip after clear", front, 1'b0);
        scan();
        rd(0, 0);
        chk("cleared 0,0", rdata, 24'h0);
        rd(R - 1, C - 1);
        chk("cleared last", rdata, 24'h0);

        // Reset mid-clear with a pending flip
        fill(24'hFFFFFF);
        pulse_flip();
        frame_end();
        chk("front before 2nd clear", front, 1'b1);
        fill(24'hFFFFFF);
        clear = 1'b1; flip_req = 1'b1;
        tick();
        clear = 1'b0; flip_req = 1'b0;
        repeat (99) tick();
        rd(3, 7);
        chk("rdata before reset", rdata, 24'hFFFFFF);
        chk("busy before reset", busy, 1'b1);
        do_reset();
        rd(0, 0);
        chk("partial clear head", rdata, 24'h0);
        rd(R - 1, C - 1);
        chk("partial clear tail", rdata, 24'hFFFFFF);
        scan();
`else
        // Clear is ignored without the engine
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("no-engine busy", busy, 1'b0);
        chk("no-engine wready", wready, 1'b1);
        // Reset with a pending flip and a loaded rdata
        pulse_flip();
        rd(3, 7);
        chk("rdata before reset", rdata, 24'hA5A5A5);
        do_reset();
        rd(3, 7);
        chk("front buffer after reset", rdata, 24'h0);
`endif

        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/display_framebuffer.md
# display_framebuffer

Double-buffered, parametrised pixel framebuffer between the frame composer (write side) and the panel scan driver (read side). The composer always writes the back buffer and the scan driver always reads the front buffer. A flip request is deferred until the scan driver finishes a frame, so a visible frame is never torn. An optional clear engine zeroes the back buffer without composer involvement.

## Interface
Parameters:
- segments, 1: number of panel segments packed side by side per word.
- rows, 8: rows per buffer; any value ≥ 2, need not be a power of two.
- columns, 32: columns per buffer; any value ≥ 2, need not be a power of two.
- width, 24: bits per pixel per segment.

Ports (clock and reset first):
- clk  input  1  sole clock; all logic on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- wen  input  segments  per-segment write enable; bit s writes wdata slice [s*width +: width].
- wrow  input  $clog2(rows)  write row (back buffer).
- wcol  input  $clog2(columns)  write column (back buffer).
- wdata  input  width*segments  write data.
- wready  output  1  high when host writes are accepted (low during a clear).
- ren  input  1  read strobe from the scan driver.
- rrow  input  $clog2(rows)  read row (front buffer).
- rcol  input  $clog2(columns)  read column (front buffer).
- rdata  output  width*segments  registered read data.
- flip_req  input  1  single-cycle request to swap buffers at the next frame end.
- flip_pending  output  1  flip latched, not yet applied.
- front  output  1  index of the buffer currently being scanned.
- clear  input  1  single-cycle request to zero the back buffer (CLEAR_EN builds only).
- busy  output  1  clear in progress.

## Operation
- Storage: 2 × rows × columns words of width*segments bits, addressed as {buffer, row, col}. Contents are zero at initial load. Reset does not clear storage.
- Write: when wen[s] && wready && wrow<rows && wcol<columns, slice s of {!front, wrow, wcol} takes wdata slice s. Other slices are unchanged. Out-of-range writes are dropped.
- Read: when ren is high, rdata loads mem[{front, rrow, rcol}], or 0 if the address is out of range. When ren is low, rdata holds.
- Frame end: the cycle in which ren && rrow==rows-1 && rcol==columns-1.
- Flip:
  - flip_req sets flip_pending; a request while already pending is absorbed, so flips never queue.
  - front toggles and flip_pending clears on the edge after a frame-end cycle, provided flip_pending is set (a flip_req in that same cycle counts) and the state is IDLE.
  - The frame-end read itself uses the old front.
- State machine (CLEAR_EN): IDLE, CLEAR.
  - IDLE → CLEAR on clear.
  - CLEAR visits every valid address of the back buffer, row-major (row 0 col 0 through row rows-1 col columns-1), writing all-zero words at one word per cycle.
  - CLEAR → IDLE after the last word.
  - clear in CLEAR is ignored.
- Simultaneous events:
  - clear and flip_req in the same IDLE cycle: clear starts and the flip is latched. The flip applies at the first frame end after returning to IDLE.
  - Frame end during CLEAR: no flip, pending stays set.
  - A host write colliding with the first clear cycle is dropped, because wready is low for that whole cycle.

## Timing
- Reset values: rdata=0, front=0, flip_pending=0, busy=0, wready=1, state IDLE, clear counters 0. Reset mid-clear aborts the sweep; the back buffer is left partially cleared.
- Read latency: 1 cycle from ren to rdata.
- Write-to-visible: a written word appears on rdata only after a flip.
- wready = !busy, combinational from state. busy goes high the edge after clear is sampled and stays high for exactly rows*columns cycles.
- flip_pending is visible the cycle after flip_req; front changes the cycle after the frame-end read.

## Configuration
- DISPLAY_FRAMEBUFFER_CLEAR_EN defined:
  - the clear engine, the CLEAR state and the clear input are built;
  - busy and wready follow the rules above.
- Undefined:
  - the clear input is present but ignored;
  - busy is tied 0 and wready tied 1;
  - there is no CLEAR state, so flips are gated only by frame end.

## Test plan
- Reset then read (0,0) with ren → rdata=0 one cycle later, front=0, wready=1.
- Write 24'hA5A5A5 to (3,7), then read (3,7) → 0. Pulse flip_req, read through to (7,31) → front=1 next cycle, then a read of (3,7) → 24'hA5A5A5.
- Pulse flip_req twice before a frame end → exactly one toggle; flip_pending=1 until the (7,31) read, 0 after.
- With segments=2, write wen=2'b10 with wdata=48'h123456_ABCDEF over a back word of 48'hFFFFFF_000000 → after flip, read returns 48'h123456_000000.
- CLEAR_EN: fill the back buffer with 1s, pulse clear and flip_req together → busy high for 256 cycles and wready=0. Frame end during that window does not flip. The next frame end flips, and all 256 words then read 0.
- Assert rst_n low mid-clear and mid-pending-flip → busy=0, flip_pending=0, front=0, rdata=0 immediately; uncleared words retain old data.
